// File: rtl/sa_fault_tester_if.sv
// Signal bundle between the stuck-at-0 fault tester and its environment:
// run control, circuit-under-test observations, pattern drive and results.
interface sa_fault_tester_if;
    logic        start;
    logic        z;
    logic        z_sa0;
    logic [3:0]  pat;
    logic        fault_val;
    logic        busy;
    logic        done;
    logic [15:0] detect_mask;
    logic [4:0]  detect_cnt;
    logic [3:0]  first_det;
    logic        first_valid;
    logic [7:0]  signature;

    modport master (
        output start, z, z_sa0,
        input  pat, fault_val, busy, done, detect_mask, detect_cnt,
               first_det, first_valid, signature
    );

    modport slave (
        input  start, z, z_sa0,
        output pat, fault_val, busy, done, detect_mask, detect_cnt,
               first_det, first_valid, signature
    );
endinterface

// File: rtl/sa_fault_tester.sv
// Exhaustive 4-input pattern sweep that compares good and stuck-at-0 circuit
// outputs, records detecting patterns and compacts z into an 8-bit MISR.
module sa_fault_tester #(
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    sa_fault_tester_if.slave  bus
);
    // state  | meaning
    // IDLE   | waiting for start; results hold their last values
    // APPLY  | current pattern driven, settle counter running
    // SAMPLE | compare z against z_sa0, update results, advance pattern
    // DONE   | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

    state_t      state, state_nxt;
    logic [3:0]  settle_cnt;
    logic [3:0]  pat;
    logic [15:0] detect_mask;
    logic [4:0]  detect_cnt;
    logic [3:0]  first_det;
    logic        first_valid;
    logic [7:0]  signature;
    logic        det;
    logic [7:0]  sig_nxt;

    assign det     = bus.z ^ bus.z_sa0;
    assign sig_nxt = {signature[6:0], 1'b0} ^ (signature[7] ? 8'h1D : 8'h00)
                   ^ {7'b0, bus.z};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = APPLY;
            APPLY:   if (settle_cnt == 4'd0) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = (pat == 4'd15) ? DONE : APPLY;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt  <= 4'd0;
            pat         <= 4'd0;
            detect_mask <= 16'h0000;
            detect_cnt  <= 5'd0;
            first_det   <= 4'd0;
            first_valid <= 1'b0;
            signature   <= 8'hFF;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        pat         <= 4'd0;
                        detect_mask <= 16'h0000;
                        detect_cnt  <= 5'd0;
                        first_det   <= 4'd0;
                        first_valid <= 1'b0;
                        signature   <= 8'hFF;
                        settle_cnt  <= SETTLE_LD;
                    end
                end
                APPLY: begin
                    if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
                end
                SAMPLE: begin
                    detect_mask[pat] <= det;
                    detect_cnt       <= detect_cnt + {4'b0, det};
                    if (det && !first_valid) begin
                        first_det   <= pat;
                        first_valid <= 1'b1;
                    end
                    signature <= sig_nxt;
                    // pat parks at 15 on the last pattern so it never wraps mid-run
                    if (pat != 4'd15) begin
                        pat        <= pat + 4'd1;
                        settle_cnt <= SETTLE_LD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pat         = pat;
    assign bus.fault_val   = 1'b0;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.detect_mask = detect_mask;
    assign bus.detect_cnt  = detect_cnt;
    assign bus.first_det   = first_det;
    assign bus.first_valid = first_valid;
    assign bus.signature   = signature;
endmodule

// File: tb/tb_sa_fault_tester.sv
// Scoreboard bench for sa_fault_tester: two instances (SETTLE=1 and SETTLE=3)
// swept with circuit tables; a queue-based monitor checks every done pulse.
module tb_sa_fault_tester;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic real_mode = 1'b1;
    logic tz  [16];
    logic tzs [16];

    typedef struct {
        logic [15:0] mask;
        logic [4:0]  cnt;
        logic [3:0]  fd;
        logic        fv;
        logic [7:0]  sig;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t last_exp;
    int total = 0;
    int bad = 0;

    sa_fault_tester_if if1();
    sa_fault_tester_if if3();

    sa_fault_tester #(.SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    sa_fault_tester #(.SETTLE(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    always #5 clk = ~clk;

    assign if1.start = start;
    assign if3.start = start;
    assign if1.z = tz[if1.pat];
    assign if3.z = tz[if3.pat];
    // in real-circuit mode the faulty net is the tester's own fault_val drive
    assign if1.z_sa0 = real_mode ? ((if1.pat[3] & if1.pat[2]) ^ ~if1.fault_val) : tzs[if1.pat];
    assign if3.z_sa0 = real_mode ? ((if3.pat[3] & if3.pat[2]) ^ ~if3.fault_val) : tzs[if3.pat];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model();
        exp_t e;
        int sig = 'hFF;
        e.mask = '0; e.cnt = '0; e.fd = '0; e.fv = 1'b0;
        for (int p = 0; p < 16; p++) begin
            int d = (tz[p] != tzs[p]) ? 1 : 0;
            if (d == 1) begin
                e.mask[p] = 1'b1;
                e.cnt = e.cnt + 5'd1;
                if (!e.fv) begin e.fd = 4'(p); e.fv = 1'b1; end
            end
            sig = ((sig * 2) % 256) ^ ((sig >= 128) ? 'h1D : 0) ^ (tz[p] ? 1 : 0);
        end
        e.sig = 8'(sig);
        return e;
    endfunction

    task automatic score(input int id, input logic [15:0] mask, input logic [4:0] cnt,
                         input logic [3:0] fd, input logic fv, input logic [7:0] sig,
                         input logic [3:0] pat, input int cyc);
        exp_t e;
        if ((id == 1 && q1.size() == 0) || (id == 3 && q3.size() == 0)) begin
            chk($sformatf("unexpected_done%0d", id), 1, 0);
            return;
        end
        e = (id == 1) ? q1.pop_front() : q3.pop_front();
        chk($sformatf("mask%0d", id), mask, e.mask);
        chk($sformatf("cnt%0d", id), cnt, e.cnt);
        chk($sformatf("first_det%0d", id), fd, e.fd);
        chk($sformatf("first_valid%0d", id), fv, e.fv);
        chk($sformatf("signature%0d", id), sig, e.sig);
        chk($sformatf("pat_at_done%0d", id), pat, 15);
        chk($sformatf("run_cycles%0d", id), cyc, (id == 1) ? 33 : 65);
    endtask

    int cyc1, cyc3;
    logic pb1, pb3, idle_chk1, idle_chk3;

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc1 = 0; pb1 = 0; idle_chk1 = 0;
        end else begin
            if (idle_chk1) begin chk("busy_after_done1", if1.busy, 0); idle_chk1 = 0; end
            if (if1.busy) cyc1 = pb1 ? cyc1 + 1 : 1;
            if (if1.done) begin
                score(1, if1.detect_mask, if1.detect_cnt, if1.first_det, if1.first_valid,
                      if1.signature, if1.pat, cyc1);
                idle_chk1 = 1;
            end
            pb1 = if1.busy;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc3 = 0; pb3 = 0; idle_chk3 = 0;
        end else begin
            if (idle_chk3) begin chk("busy_after_done3", if3.busy, 0); idle_chk3 = 0; end
            if (if3.busy) cyc3 = pb3 ? cyc3 + 1 : 1;
            if (if3.done) begin
                score(3, if3.detect_mask, if3.detect_cnt, if3.first_det, if3.first_valid,
                      if3.signature, if3.pat, cyc3);
                idle_chk3 = 1;
            end
            pb3 = if3.busy;
        end
    end

    task automatic set_real();
        real_mode = 1'b1;
        for (int p = 0; p < 16; p++) begin
            tz[p]  = (p[3] & p[2]) ^ ~(p[1] | p[0]);
            tzs[p] = (p[3] & p[2]) ^ 1'b1;
        end
    endtask

    task automatic set_table(input int kind);
        real_mode = 1'b0;
        for (int p = 0; p < 16; p++) begin
            tz[p]  = (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            tzs[p] = (kind == 1) ? tz[p] : (kind == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic push_both();
        last_exp = model();
        q1.push_back(last_exp);
        q3.push_back(last_exp);
    endtask

    task automatic wait_quiet();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!if1.busy && !if3.busy && q1.size() == 0 && q3.size() == 0) return;
        end
        chk("wait_quiet_timeout", 1, 0);
    endtask

    task automatic run();
        @(negedge clk);
        start = 1'b1;
        push_both();
        @(negedge clk);
        start = 1'b0;
        wait_quiet();
    endtask

    task automatic wait_pat1(input logic [3:0] v);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (if1.pat == v && if1.busy) return;
        end
        chk("wait_pat_timeout", 1, 0);
    endtask

    task automatic chk_reset(input string n, input logic [3:0] pat, input logic busy,
                             input logic done, input logic [15:0] mask, input logic [4:0] cnt,
                             input logic [3:0] fd, input logic fv, input logic [7:0] sig,
                             input logic fval);
        chk({n, "_rst_pat"}, pat, 0);
        chk({n, "_rst_busy"}, busy, 0);
        chk({n, "_rst_done"}, done, 0);
        chk({n, "_rst_mask"}, mask, 0);
        chk({n, "_rst_cnt"}, cnt, 0);
        chk({n, "_rst_first"}, {fv, fd}, 0);
        chk({n, "_rst_sig"}, sig, 8'hFF);
        chk({n, "_rst_fault_val"}, fval, 0);
    endtask

    task automatic reset_checks();
        chk_reset("d1", if1.pat, if1.busy, if1.done, if1.detect_mask, if1.detect_cnt,
                  if1.first_det, if1.first_valid, if1.signature, if1.fault_val);
        chk_reset("d3", if3.pat, if3.busy, if3.done, if3.detect_mask, if3.detect_cnt,
                  if3.first_det, if3.first_valid, if3.signature, if3.fault_val);
    endtask

    initial begin
        set_real();
        #12;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;

        // real circuit, SETTLE=1 and SETTLE=3 side by side
        run();
        chk("real_cnt", if1.detect_cnt, 12);
        chk("real_mask", if1.detect_mask, 16'hEEEE);
        chk("real_first", {if1.first_valid, if1.first_det}, 5'h11);
        chk("real_mask_s3", if3.detect_mask, 16'hEEEE);
        repeat (5) @(negedge clk);
        chk("hold_mask", if1.detect_mask, last_exp.mask);
        chk("hold_sig", if1.signature, last_exp.sig);
        chk("hold_sig_s3", if3.signature, last_exp.sig);

        set_table(1);
        run();
        chk("tied_cnt", if1.detect_cnt, 0);
        chk("tied_fv", if1.first_valid, 0);

        set_table(2);
        run();
        chk("all_cnt", if1.detect_cnt, 16);
        chk("all_mask", if1.detect_mask, 16'hFFFF);
        chk("all_first", {if1.first_valid, if1.first_det}, 5'h10);

        for (int k = 0; k < 4; k++) begin
            set_table(0);
            run();
        end

        // reset mid-run discards partial results
        set_real();
        @(negedge clk);
        start = 1'b1;
        push_both();
        @(negedge clk);
        start = 1'b0;
        wait_pat1(4'd7);
        rst_n = 1'b0;
        #1;
        reset_checks();
        q1.delete();
        q3.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run();
        chk("post_reset_mask", if1.detect_mask, 16'hEEEE);

        // start re-pulsed mid-run is ignored; start held across DONE restarts
        @(negedge clk);
        start = 1'b1;
        push_both();
        @(negedge clk);
        start = 1'b0;
        wait_pat1(4'd5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_pat1(4'd12);
        start = 1'b1;
        q1.push_back(model());
        for (int i = 0; i < 100 && !if1.done; i++) @(negedge clk);
        @(negedge clk);
        chk("held_idle_gap", if1.busy, 0);
        @(negedge clk);
        chk("held_restart", if1.busy, 1);
        chk("held_restart_pat", if1.pat, 0);
        start = 1'b0;
        wait_quiet();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=1 expected=0");
        $fatal(1, "timeout");
    end
endmodule
